// File: rtl/rst_seq_pkg.sv
// Shared types, cause-bit index helpers and a small simulation parameter set
// for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        SEQ  = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Reduced timing so a simulation walks through every phase in a few hundred cycles.
    localparam int SIM_N_REQ       = 2;
    localparam int SIM_N_LOCK      = 1;
    localparam int SIM_N_OUT       = 3;
    localparam int SIM_CNT_W       = 21;
    localparam int SIM_FLT_CYC     = 10;
    localparam int SIM_LOCK_CYC    = 8;
    localparam int SIM_STRETCH_CYC = 4;
    localparam int SIM_GAP_CYC     = 3;

    function automatic int cause_req_idx(input int i);
        return i;
    endfunction

    function automatic int cause_lock_idx(input int n_req, input int j);
        return n_req + j;
    endfunction

    function automatic int cause_soft_idx(input int n_req, input int n_lock);
        return n_req + n_lock;
    endfunction

endpackage

// File: rtl/rst_sat_cnt.sv
// Saturating up-counter with synchronous clear; counts every cycle the clear
// is low and parks at MAX instead of wrapping.
module rst_sat_cnt #(
    parameter int               CNT_W = 21,
    parameter logic [CNT_W-1:0] MAX   = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/rst_seq_mgr.sv
// FPGA reset manager: filters reset requests, qualifies PLL lock, then releases
// the reset outputs one stage at a time and keeps sticky reset-cause bits.
module rst_seq_mgr
    import rst_seq_pkg::*;
#(
    parameter int          N_REQ       = 2,
    parameter int          N_LOCK      = 1,
    parameter int          N_OUT       = 3,
    parameter int          CNT_W       = 21,
    parameter int unsigned FLT_CYC     = 21'h1312D0,
    parameter int unsigned LOCK_CYC    = 254,
    parameter int unsigned STRETCH_CYC = 8,
    parameter int unsigned GAP_CYC     = 16
) (
    input  logic                    fpga_10m_clk,
    input  logic                    fpga_rst_n,
    input  logic [N_REQ-1:0]        rst_req_n,
    input  logic [N_LOCK-1:0]       pll_locked,
    input  logic                    soft_rst,
    input  logic                    cause_clr,
    output logic [N_OUT-1:0]        rst_out,
    output logic                    rst_done,
    output logic [N_REQ+N_LOCK:0]   rst_cause
);

    localparam int CW    = N_REQ + N_LOCK + 1;
    localparam int STG_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [CNT_W-1:0] FLT_MAX  = CNT_W'(FLT_CYC);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYC);
    localparam logic [CNT_W-1:0] STR_MAX  = CNT_W'(STRETCH_CYC);
    localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(STRETCH_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_MAX  = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(N_OUT - 1);

    // Lock terms start out active, so their edge history resets high and the
    // power-up lock acquisition is not logged as a lock loss.
    localparam logic [CW-1:0] PREV_RST = {1'b0, {N_LOCK{1'b1}}, {N_REQ{1'b0}}};

    logic [N_REQ-1:0]  req_s1_q, req_s2_q;
    logic [N_LOCK-1:0] lock_s1_q, lock_s2_q;

    logic [CNT_W-1:0]  flt_cnt  [N_REQ];
    logic [CNT_W-1:0]  lock_cnt [N_LOCK];
    logic [CNT_W-1:0]  stretch_cnt, gap_cnt;
    logic [N_REQ-1:0]  req_act;
    logic [N_LOCK-1:0] lock_ok;
    logic              trigger, gap_hit;

    logic [CW-1:0]     terms, trig_prev_q, cause_q, cause_d;

    state_e            state_q, state_d;
    logic [STG_W-1:0]  stage_q, stage_d;
    logic [N_OUT-1:0]  out_q, out_d;
    logic              done_q, done_d;

    always_ff @(posedge fpga_10m_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            req_s1_q  <= '0;
            req_s2_q  <= '0;
            lock_s1_q <= '0;
            lock_s2_q <= '0;
        end else begin
            req_s1_q  <= rst_req_n;
            req_s2_q  <= req_s1_q;
            lock_s1_q <= pll_locked;
            lock_s2_q <= lock_s1_q;
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_flt
        rst_sat_cnt #(.CNT_W(CNT_W), .MAX(FLT_MAX)) u_flt (
            .clk_i  (fpga_10m_clk),
            .rst_ni (fpga_rst_n),
            .clr_i  (req_s2_q[i]),
            .cnt_o  (flt_cnt[i])
        );
        assign req_act[i] = (flt_cnt[i] == FLT_MAX);
    end

    for (genvar j = 0; j < N_LOCK; j++) begin : g_lock
        rst_sat_cnt #(.CNT_W(CNT_W), .MAX(LOCK_MAX)) u_lock (
            .clk_i  (fpga_10m_clk),
            .rst_ni (fpga_rst_n),
            .clr_i  (~lock_s2_q[j]),
            .cnt_o  (lock_cnt[j])
        );
        assign lock_ok[j] = lock_s2_q[j] && (lock_cnt[j] == LOCK_MAX);
    end

    assign terms   = {soft_rst, ~lock_ok, req_act};
    assign trigger = |terms;
    assign gap_hit = (gap_cnt == GAP_LAST);

    rst_sat_cnt #(.CNT_W(CNT_W), .MAX(STR_MAX)) u_stretch (
        .clk_i  (fpga_10m_clk),
        .rst_ni (fpga_rst_n),
        .clr_i  (trigger || (state_q != HOLD)),
        .cnt_o  (stretch_cnt)
    );

    rst_sat_cnt #(.CNT_W(CNT_W), .MAX(GAP_MAX)) u_gap (
        .clk_i  (fpga_10m_clk),
        .rst_ni (fpga_rst_n),
        .clr_i  ((state_q != SEQ) || gap_hit),
        .cnt_o  (gap_cnt)
    );

    // A cause bit latches on the rising edge of its term; a new set outranks a clear.
    always_comb begin
        cause_d = (cause_clr ? '0 : cause_q) | (terms & ~trig_prev_q);
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        out_d   = out_q;
        done_d  = done_q;
        unique case (state_q)
            HOLD: begin
                out_d  = '1;
                done_d = 1'b0;
                if (!trigger && (stretch_cnt == STR_LAST)) begin
                    state_d = SEQ;
                    stage_d = '0;
                end
            end
            SEQ: begin
                if (trigger) begin
                    state_d = HOLD;
                    out_d   = '1;
                    done_d  = 1'b0;
                end else if (gap_hit) begin
                    out_d[stage_q] = 1'b0;
                    if (stage_q == LAST_STG) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        stage_d = stage_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (trigger) begin
                    state_d = HOLD;
                    out_d   = '1;
                    done_d  = 1'b0;
                end else begin
                    out_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = HOLD;
                out_d   = '1;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge fpga_10m_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            state_q     <= HOLD;
            stage_q     <= '0;
            out_q       <= '1;
            done_q      <= 1'b0;
            cause_q     <= '0;
            trig_prev_q <= PREV_RST;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            out_q       <= out_d;
            done_q      <= done_d;
            cause_q     <= cause_d;
            trig_prev_q <= terms;
        end
    end

    assign rst_out   = out_q;
    assign rst_done  = done_q;
    assign rst_cause = cause_q;

endmodule

// File: tb/tb_rst_seq_mgr.sv
// Scoreboard bench for rst_seq_mgr: every expected change of {rst_done, rst_out}
// is queued with its edge number when stimulus is driven and checked on arrival.
module tb_rst_seq_mgr;
   import rst_seq_pkg::*;

   localparam int NC = SIM_N_REQ + SIM_N_LOCK + 1;
   localparam int S  = SIM_STRETCH_CYC;
   localparam int G  = SIM_GAP_CYC;

   logic                  fpga_10m_clk = 1'b0;
   logic                  fpga_rst_n   = 1'b0;
   logic [SIM_N_REQ-1:0]  rst_req_n    = '1;
   logic [SIM_N_LOCK-1:0] pll_locked   = '1;
   logic                  soft_rst     = 1'b0;
   logic                  cause_clr    = 1'b0;
   logic [SIM_N_OUT-1:0]  rst_out;
   logic                  rst_done;
   logic [NC-1:0]         rst_cause;

   typedef struct {
      int         edgeN;
      logic [3:0] val;
   } exp_t;

   exp_t       expQ[$];
   int         edgeCnt     = 0;
   int         vectors     = 0;
   int         miscompares = 0;
   logic [3:0] prevObs     = 4'b0111;

   rst_seq_mgr #(
      .N_REQ       (SIM_N_REQ),
      .N_LOCK      (SIM_N_LOCK),
      .N_OUT       (SIM_N_OUT),
      .CNT_W       (SIM_CNT_W),
      .FLT_CYC     (SIM_FLT_CYC),
      .LOCK_CYC    (SIM_LOCK_CYC),
      .STRETCH_CYC (SIM_STRETCH_CYC),
      .GAP_CYC     (SIM_GAP_CYC)
   ) dut (
      .fpga_10m_clk (fpga_10m_clk),
      .fpga_rst_n   (fpga_rst_n),
      .rst_req_n    (rst_req_n),
      .pll_locked   (pll_locked),
      .soft_rst     (soft_rst),
      .cause_clr    (cause_clr),
      .rst_out      (rst_out),
      .rst_done     (rst_done),
      .rst_cause    (rst_cause)
   );

   // 10 MHz-style free-running clock and an edge counter used as the time base
   always #5 fpga_10m_clk = ~fpga_10m_clk;

   always @(posedge fpga_10m_clk) edgeCnt <= edgeCnt + 1;

   // Single comparison point: counts every vector and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edgeCnt);
      end
   endtask

   task automatic expectAt(input int edgeN, input logic [3:0] val);
      exp_t e;
      e.edgeN = edgeN;
      e.val   = val;
      expQ.push_back(e);
   endtask

   // Release schedule when the last trigger cycle is sampled at edge t
   task automatic expectRelease(input int t);
      expectAt(t + S + G,     4'b0110);
      expectAt(t + S + 2 * G, 4'b0100);
      expectAt(t + S + 3 * G, 4'b1000);
   endtask

   task automatic applyStimulus(output int b);
      @(posedge fpga_10m_clk);
      #1;
      b = edgeCnt;
   endtask

   task automatic gotoEdge(input int n);
      while (edgeCnt < n) begin
         @(posedge fpga_10m_clk);
         #1;
      end
   endtask

   task automatic waitDrain(input string tag, input int budget);
      int k = 0;
      while (expQ.size() != 0 && k < budget) begin
         @(posedge fpga_10m_clk);
         #1;
         k++;
      end
      repeat (3) begin
         @(posedge fpga_10m_clk);
         #1;
      end
      checkOutput(tag, 32'(expQ.size()), 32'd0);
      expQ.delete();
   endtask

   // Output monitor: any change of {rst_done, rst_out} must match the queue head
   always @(negedge fpga_10m_clk) begin
      logic [3:0] cur;
      exp_t       e;
      cur = {rst_done, rst_out};
      if (cur !== prevObs) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedChange", 32'(cur), 32'(prevObs));
         end else begin
            e = expQ.pop_front();
            checkOutput("outValue", 32'(cur), 32'(e.val));
            checkOutput("outEdge", 32'(edgeCnt), 32'(e.edgeN));
         end
         prevObs = cur;
      end
   end

   // Scenario sequence from power-up through async reset recovery
   initial begin
      int b;
      logic [31:0] cReq1, cLock, cSoft;
      cReq1 = 32'd1 << cause_req_idx(1);
      cLock = 32'd1 << cause_lock_idx(SIM_N_REQ, 0);
      cSoft = 32'd1 << cause_soft_idx(SIM_N_REQ, SIM_N_LOCK);

      repeat (3) @(posedge fpga_10m_clk);
      #1;
      checkOutput("resetOut", 32'(rst_out), 32'h7);
      checkOutput("resetDone", 32'(rst_done), 32'h0);
      checkOutput("resetCause", 32'(rst_cause), 32'h0);

      fpga_rst_n = 1'b1;
      b = edgeCnt;
      expectRelease(b + 10);
      waitDrain("powerUpDrain", 60);
      checkOutput("powerUpCause", 32'(rst_cause), 32'h0);

      applyStimulus(b);
      rst_req_n[0] = 1'b0;
      gotoEdge(b + 8);
      rst_req_n[0] = 1'b1;
      gotoEdge(b + 20);
      checkOutput("glitchOut", 32'(rst_out), 32'h0);
      checkOutput("glitchDone", 32'(rst_done), 32'h1);
      checkOutput("glitchCause", 32'(rst_cause), 32'h0);

      applyStimulus(b);
      rst_req_n[1] = 1'b0;
      expectAt(b + 13, 4'b0111);
      gotoEdge(b + 20);
      rst_req_n[1] = 1'b1;
      expectRelease(b + 23);
      waitDrain("reqDrain", 40);
      checkOutput("reqCause", 32'(rst_cause), cReq1);

      applyStimulus(b);
      soft_rst = 1'b1;
      expectAt(b + 1, 4'b0111);
      expectAt(b + 8, 4'b0110);
      gotoEdge(b + 1);
      soft_rst = 1'b0;
      gotoEdge(b + 9);
      soft_rst = 1'b1;
      expectAt(b + 10, 4'b0111);
      gotoEdge(b + 10);
      soft_rst = 1'b0;
      expectRelease(b + 10);
      waitDrain("softDrain", 40);
      checkOutput("softCause", 32'(rst_cause), cReq1 | cSoft);

      applyStimulus(b);
      pll_locked[0] = 1'b0;
      expectAt(b + 3, 4'b0111);
      gotoEdge(b + 1);
      pll_locked[0] = 1'b1;
      expectRelease(b + 11);
      waitDrain("lockDrain", 40);
      checkOutput("lockCause", 32'(rst_cause), cReq1 | cLock | cSoft);

      applyStimulus(b);
      soft_rst = 1'b1;
      expectAt(b + 1, 4'b0111);
      expectAt(b + 8, 4'b0110);
      gotoEdge(b + 1);
      soft_rst = 1'b0;
      gotoEdge(b + 10);
      soft_rst  = 1'b1;
      cause_clr = 1'b1;
      expectAt(b + 11, 4'b0111);
      gotoEdge(b + 11);
      soft_rst  = 1'b0;
      cause_clr = 1'b0;
      checkOutput("collideCause", 32'(rst_cause), cSoft);
      expectRelease(b + 11);
      waitDrain("collideDrain", 40);

      applyStimulus(b);
      cause_clr = 1'b1;
      gotoEdge(b + 1);
      cause_clr = 1'b0;
      checkOutput("clearCause", 32'(rst_cause), 32'h0);

      applyStimulus(b);
      soft_rst = 1'b1;
      expectAt(b + 1, 4'b0111);
      expectAt(b + 8, 4'b0110);
      gotoEdge(b + 1);
      soft_rst = 1'b0;
      gotoEdge(b + 9);
      expectAt(b + 9, 4'b0111);
      #2;
      fpga_rst_n = 1'b0;
      #1;
      checkOutput("asyncOut", 32'(rst_out), 32'h7);
      checkOutput("asyncCause", 32'(rst_cause), 32'h0);
      gotoEdge(b + 12);
      fpga_rst_n = 1'b1;
      b = edgeCnt;
      expectRelease(b + 10);
      waitDrain("asyncDrain", 60);
      checkOutput("asyncDone", 32'(rst_done), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard time limit so a stuck design can never hang the run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
